shield_arbiter: RTL and testbench
=================================

// Module: shield_arbiter
// PURPOSE
//  Sequences the starship's left/right shields. Arbitrates both shield buttons onto one shared energy pool.
//  Runs a per-side IDLE/ACTIVE/COOLDOWN timer paced by the display frame tick.
//  Outputs drive the left/right shield pixel-fill enables in the pixel generator.
//  Sits between the debounced buttons and the VGA object renderer; clocked on the system clock.
// PARAMETERS
//  ACTIVE_FRAMES    60  frames a granted shield stays up (>=1)
//  COOLDOWN_FRAMES  30  frames a side is locked out after its shield drops (>=1)
//  ENERGY_MAX       8   energy pool capacity; reset value; 1 unit per activation
//  RECHARGE_FRAMES  45  frames per +1 energy while pool < ENERGY_MAX
//  BLINK_FRAMES     16  final ACTIVE frames that blink (used only with SHIELD_BLINK_EN)
// PORTS
//  clk              in   1   system clock
//  rst_n            in   1   asynchronous active-low reset
//  frame_tick       in   1   1-cycle pulse per frame (vCount wrap)
//  btn_left         in   1   debounced level, left shield request
//  btn_right        in   1   debounced level, right shield request
//  left_shield_on   out  1   left shield visible (registered)
//  right_shield_on  out  1   right shield visible (registered)
//  left_state       out  2   left FSM state encoding
//  right_state      out  2   right FSM state encoding
//  energy           out  4   current pool level, 0..ENERGY_MAX
//  denied           out  1   1-cycle pulse: request dropped for lack of energy
// BEHAVIOUR
//  Reset: both FSMs IDLE, shield_on=0, energy=ENERGY_MAX, recharge count=0, rr_ptr=LEFT, denied=0, button history regs=0.
//  Request = rising edge of btn_x (btn_x & ~btn_x_q). Levels held high never re-request.
//  Requests arriving in ACTIVE or COOLDOWN are discarded, never queued; denied stays 0.
//  Grant: side IDLE, request, energy>0. Next edge: FSM ACTIVE, shield_on=1, energy-1, frame cnt=ACTIVE_FRAMES.
//   Latency from request edge to shield_on=1 is 1 clk.
//  Simultaneous requests, both IDLE: energy>=2 grants both (energy-2).
//   energy==1 grants the side at rr_ptr only; rr_ptr flips to the other side; denied=1.
//   energy==0 grants none; denied=1.
//  rr_ptr also flips after any single-side grant, to point at the opposite side.
//  ACTIVE: frame cnt decrements on frame_tick. On a frame_tick with cnt==1: go to COOLDOWN, cnt=COOLDOWN_FRAMES, shield_on=0.
//  COOLDOWN: same decrement. On a frame_tick with cnt==1: go to IDLE.
//  Recharge: while energy<ENERGY_MAX, rc counts frame_ticks; at RECHARGE_FRAMES, rc=0 and energy+1.
//   At ENERGY_MAX, rc is held at 0.
//  Same-cycle grant + recharge: energy_next = energy - grants + 1, saturating at ENERGY_MAX; never underflows.
//  frame_tick and a request in the same cycle: the grant loads a full ACTIVE_FRAMES; that tick is not counted.
//  rst_n low mid-ACTIVE: shields drop immediately (async); all state returns to reset values.
// CONFIGURATION
//  SHIELD_BLINK_EN defined: in the final BLINK_FRAMES of ACTIVE (cnt<=BLINK_FRAMES), shield_on toggles on each frame_tick.
//   Phase starts at 1. State and energy are unaffected.
//  SHIELD_BLINK_EN undefined: shield_on=1 for the whole of ACTIVE; no blink logic is built.
// STRUCTURE
//  Package shield_pkg holds:
//   state enum IDLE=2'd0, ACTIVE=2'd1, COOLDOWN=2'd2 (2'd3 illegal; decodes to IDLE);
//   SIDE_LEFT/SIDE_RIGHT constants; frame-count width function (clog2 of max frames).
//  Sub-module shield_side_fsm: edge detect, state, frame counter, blink phase, shield_on.
//   Instantiated twice, one per side; takes grant in, drives req/idle out.
//  Top level holds the arbiter, rr_ptr, energy pool, and recharge counter.
// TESTING
//  Defaults; btn_left high 1 clk -> next clk left_shield_on=1, energy=7; after 60 ticks on=0, state=COOLDOWN; after 30 more, IDLE.
//  Both buttons rise same clk, energy=8 -> both shields on, energy=6, denied=0.
//  energy=1, rr_ptr=LEFT, both rise -> only left on, energy=0, denied=1, rr_ptr=RIGHT.
//  energy=0, left press -> no shield, denied=1; after 45 ticks energy=1 and next press grants.
//  Left ACTIVE at tick 20, press left again, hold btn 100 frames -> no re-grant, energy unchanged by press.
//  rst_n low during ACTIVE -> shield_on=0 same cycle; after release energy=8, both IDLE.

Source files
------------

// File: rtl/shield_pkg.sv
// Shared types for the shield sequencer: per-side state encoding, side ids, counter sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shield_pkg;

  // 2'd3 is never produced; the side FSM treats it as IDLE.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  // Width needed to hold the largest frame count either phase loads.
  function automatic int frame_cnt_w(input int active_frames, input int cooldown_frames);
    int m;
    m = (active_frames > cooldown_frames) ? active_frames : cooldown_frames;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/shield_arbiter_if.sv
// Button / frame-tick inputs and shield status outputs of the shield sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; buttons are levels, frame_tick and denied are 1-cycle pulses.
// master: drives frame_tick, btn_left, btn_right; observes shield status.
// slave : the sequencer; drives left/right_shield_on, left/right_state, energy, denied.
interface shield_arbiter_if;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       left_shield_on;
  logic       right_shield_on;
  logic [1:0] left_state;
  logic [1:0] right_state;
  logic [3:0] energy;
  logic       denied;

  modport master (
    output frame_tick, btn_left, btn_right,
    input  left_shield_on, right_shield_on, left_state, right_state, energy, denied
  );

  modport slave (
    input  frame_tick, btn_left, btn_right,
    output left_shield_on, right_shield_on, left_state, right_state, energy, denied
  );
endinterface

// File: rtl/shield_side_fsm.sv
// One shield side: button edge detect, IDLE/ACTIVE/COOLDOWN sequencing, frame counter, shield_on.
// Latency: grant_i -> shield_on_o high on the next clock edge; req_o is combinational from btn_i.
// Backpressure: none; req_o is only honoured by the arbiter while idle_o, otherwise it is dropped.
// Ports: clk, rst_n; frame_tick_i, btn_i, grant_i in; req_o, idle_o, state_o, shield_on_o out.
// Optional blink of the last BLINK_FRAMES of ACTIVE is built only when SHIELD_BLINK_EN is defined.
module shield_side_fsm
  import shield_pkg::*;
#(
  parameter int ACTIVE_FRAMES   = 60,
  parameter int COOLDOWN_FRAMES = 30,
`ifdef SHIELD_BLINK_EN
  parameter int BLINK_FRAMES    = 16,
`endif
  parameter int CNT_W           = 6
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   frame_tick_i,
  input  logic   btn_i,
  input  logic   grant_i,
  output logic   req_o,
  output logic   idle_o,
  output state_e state_o,
  output logic   shield_on_o
);

  localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(ACTIVE_FRAMES);
  localparam logic [CNT_W-1:0] CD_LOAD  = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             btn_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             shield_on_q, shield_on_d;

  // A held level only ever produces one request.
  assign req_o       = btn_i & ~btn_q;
  assign idle_o      = (state_q != ACTIVE) && (state_q != COOLDOWN);
  assign state_o     = state_q;
  assign shield_on_o = shield_on_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q       <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shield_on_q <= 1'b0;
    end else begin
      btn_q       <= btn_i;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shield_on_q <= shield_on_d;
    end
  end

  // A tick landing on the grant cycle is ignored: IDLE never looks at frame_tick_i.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACTIVE: begin
        if (frame_tick_i) begin
          if (cnt_q == CNT_ONE) begin
            state_d = COOLDOWN;
            cnt_d   = CD_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      COOLDOWN: begin
        if (frame_tick_i) begin
          if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: begin
        // IDLE, and the unused encoding which behaves as IDLE.
        if (grant_i) begin
          state_d = ACTIVE;
          cnt_d   = ACT_LOAD;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

`ifdef SHIELD_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_FRAMES);

  logic phase_q, phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= 1'b1;
    else        phase_q <= phase_d;
  end

  // Phase restarts visible on every entry to ACTIVE, then flips per tick in the blink window.
  always_comb begin
    phase_d = phase_q;
    if (state_d == ACTIVE && state_q != ACTIVE)
      phase_d = 1'b1;
    else if (state_q == ACTIVE && frame_tick_i && cnt_d <= BLINK_LOAD)
      phase_d = ~phase_q;
    shield_on_d = (state_d == ACTIVE) && phase_d;
  end
`else
  always_comb begin
    shield_on_d = (state_d == ACTIVE);
  end
`endif

endmodule

// File: rtl/shield_arbiter.sv
// Arbitrates left/right shield requests onto a shared, frame-recharged energy pool.
// Latency: button rising edge -> shield_on and energy update on the next clock edge.
// Backpressure: none; requests that cannot be served are dropped (denied pulse if energy-limited).
// Ports: clk, rst_n; bus (slave): frame_tick, btn_left, btn_right in;
//        left/right_shield_on, left/right_state, energy, denied out.
// Build option SHIELD_BLINK_EN: blink the shield during the last BLINK_FRAMES of ACTIVE.
module shield_arbiter
  import shield_pkg::*;
#(
  parameter int ACTIVE_FRAMES   = 60,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int ENERGY_MAX      = 8,
`ifdef SHIELD_BLINK_EN
  parameter int BLINK_FRAMES    = 16,
`endif
  parameter int RECHARGE_FRAMES = 45
) (
  input logic             clk,
  input logic             rst_n,
  shield_arbiter_if.slave bus
);

  localparam int               CNT_W   = frame_cnt_w(ACTIVE_FRAMES, COOLDOWN_FRAMES);
  localparam int               RC_W    = $clog2(RECHARGE_FRAMES + 1);
  localparam logic [3:0]       E_MAX   = 4'(ENERGY_MAX);
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RECHARGE_FRAMES - 1);

  logic            l_req, l_idle, r_req, r_idle;
  logic            req_l, req_r, grant_l, grant_r, deny;
  state_e          l_state, r_state;
  logic            rr_q, rr_d;
  logic            denied_q;
  logic [3:0]      energy_q, energy_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic            inc;
  logic [1:0]      n_grants;
  logic [4:0]      e_sum;

  shield_side_fsm #(
    .ACTIVE_FRAMES  (ACTIVE_FRAMES),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
`ifdef SHIELD_BLINK_EN
    .BLINK_FRAMES   (BLINK_FRAMES),
`endif
    .CNT_W          (CNT_W)
  ) u_left (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick_i(bus.frame_tick),
    .btn_i       (bus.btn_left),
    .grant_i     (grant_l),
    .req_o       (l_req),
    .idle_o      (l_idle),
    .state_o     (l_state),
    .shield_on_o (bus.left_shield_on)
  );

  shield_side_fsm #(
    .ACTIVE_FRAMES  (ACTIVE_FRAMES),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
`ifdef SHIELD_BLINK_EN
    .BLINK_FRAMES   (BLINK_FRAMES),
`endif
    .CNT_W          (CNT_W)
  ) u_right (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick_i(bus.frame_tick),
    .btn_i       (bus.btn_right),
    .grant_i     (grant_r),
    .req_o       (r_req),
    .idle_o      (r_idle),
    .state_o     (r_state),
    .shield_on_o (bus.right_shield_on)
  );

  // Requests from a busy side are discarded here, so they never reach the deny logic.
  assign req_l = l_req & l_idle;
  assign req_r = r_req & r_idle;

  always_comb begin
    grant_l = 1'b0;
    grant_r = 1'b0;
    deny    = 1'b0;
    if (req_l && req_r) begin
      if (energy_q >= 4'd2) begin
        grant_l = 1'b1;
        grant_r = 1'b1;
      end else if (energy_q == 4'd1) begin
        grant_l = (rr_q == SIDE_LEFT);
        grant_r = (rr_q == SIDE_RIGHT);
        deny    = 1'b1;
      end else begin
        deny = 1'b1;
      end
    end else if (req_l) begin
      if (energy_q != 4'd0) grant_l = 1'b1;
      else                  deny    = 1'b1;
    end else if (req_r) begin
      if (energy_q != 4'd0) grant_r = 1'b1;
      else                  deny    = 1'b1;
    end
  end

  // Pointer moves away from whichever side just won alone; a double grant leaves it put.
  always_comb begin
    rr_d = rr_q;
    if (grant_l && !grant_r)      rr_d = SIDE_RIGHT;
    else if (grant_r && !grant_l) rr_d = SIDE_LEFT;
  end

  always_comb begin
    rc_d = rc_q;
    inc  = 1'b0;
    if (energy_q >= E_MAX) begin
      rc_d = '0;
    end else if (bus.frame_tick) begin
      if (rc_q == RC_LAST) begin
        rc_d = '0;
        inc  = 1'b1;
      end else begin
        rc_d = rc_q + 1'b1;
      end
    end
  end

  // Grants never exceed the current level, so the 5-bit sum cannot wrap below zero.
  always_comb begin
    n_grants = {1'b0, grant_l} + {1'b0, grant_r};
    e_sum    = {1'b0, energy_q} + {4'd0, inc} - {3'd0, n_grants};
    energy_d = (e_sum > {1'b0, E_MAX}) ? E_MAX : e_sum[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= SIDE_LEFT;
      denied_q <= 1'b0;
      energy_q <= E_MAX;
      rc_q     <= '0;
    end else begin
      rr_q     <= rr_d;
      denied_q <= deny;
      energy_q <= energy_d;
      rc_q     <= rc_d;
    end
  end

  assign bus.left_state  = l_state;
  assign bus.right_state = r_state;
  assign bus.energy      = energy_q;
  assign bus.denied      = denied_q;

endmodule

// File: tb/tb_shield_arbiter.sv
// Directed bench for shield_arbiter: default-timing instance plus a short-timing instance
// used to drain the energy pool within a reasonable number of frames.
// Ports driven through two shield_arbiter_if instances; clock and reset shared.
module tb_shield_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  shield_arbiter_if bus_a ();
  shield_arbiter_if bus_b ();

  shield_arbiter u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a.slave)
  );

  shield_arbiter #(
    .ACTIVE_FRAMES  (2),
    .COOLDOWN_FRAMES(1)
  ) u_fast (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus_a.frame_tick = 1'b1;
      bus_b.frame_tick = 1'b1;
      step();
      bus_a.frame_tick = 1'b0;
      bus_b.frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    bus_a.frame_tick = 1'b0;
    bus_a.btn_left   = 1'b0;
    bus_a.btn_right  = 1'b0;
    bus_b.frame_tick = 1'b0;
    bus_b.btn_left   = 1'b0;
    bus_b.btn_right  = 1'b0;
    do_reset();

    // Reset state
    check("rst_left_on",  32'(bus_a.left_shield_on),  0);
    check("rst_right_on", 32'(bus_a.right_shield_on), 0);
    check("rst_lstate",   32'(bus_a.left_state),      0);
    check("rst_rstate",   32'(bus_a.right_state),     0);
    check("rst_energy",   32'(bus_a.energy),          8);
    check("rst_denied",   32'(bus_a.denied),          0);

    // Single left press, full ACTIVE/COOLDOWN life cycle
    bus_a.btn_left = 1'b1;
    step();
    bus_a.btn_left = 1'b0;
    check("s1_on",     32'(bus_a.left_shield_on), 1);
    check("s1_state",  32'(bus_a.left_state),     1);
    check("s1_energy", 32'(bus_a.energy),         7);
    check("s1_denied", 32'(bus_a.denied),         0);
    tick_n(59);
    check("s1_on_59",  32'(bus_a.left_shield_on), 1);
    tick_n(1);
    check("s1_off_60", 32'(bus_a.left_shield_on), 0);
    check("s1_cd_60",  32'(bus_a.left_state),     2);
    check("s1_rech",   32'(bus_a.energy),         8);
    tick_n(29);
    check("s1_cd_89",  32'(bus_a.left_state),     2);
    tick_n(1);
    check("s1_idle_90", 32'(bus_a.left_state),    0);

    // Simultaneous presses with a full pool
    do_reset();
    bus_a.btn_left  = 1'b1;
    bus_a.btn_right = 1'b1;
    step();
    bus_a.btn_left  = 1'b0;
    bus_a.btn_right = 1'b0;
    check("s2_left_on",  32'(bus_a.left_shield_on),  1);
    check("s2_right_on", 32'(bus_a.right_shield_on), 1);
    check("s2_energy",   32'(bus_a.energy),          6);
    check("s2_denied",   32'(bus_a.denied),          0);

    // Re-press while ACTIVE and hold: discarded, no re-grant
    do_reset();
    bus_a.btn_left = 1'b1;
    step();
    bus_a.btn_left = 1'b0;
    tick_n(20);
    bus_a.btn_left = 1'b1;
    step();
    check("s3_energy", 32'(bus_a.energy),     7);
    check("s3_denied", 32'(bus_a.denied),     0);
    check("s3_state",  32'(bus_a.left_state), 1);
    tick_n(100);
    check("s3_idle",   32'(bus_a.left_state),     0);
    check("s3_off",    32'(bus_a.left_shield_on), 0);
    check("s3_energy_end", 32'(bus_a.energy),     8);
    bus_a.btn_left = 1'b0;
    step();

    // Async reset during ACTIVE
    do_reset();
    bus_a.btn_left = 1'b1;
    step();
    bus_a.btn_left = 1'b0;
    tick_n(5);
    check("s4_on_pre", 32'(bus_a.left_shield_on), 1);
    rst_n = 1'b0;
    #1;
    check("s4_async_off", 32'(bus_a.left_shield_on), 0);
    step();
    rst_n = 1'b1;
    step();
    check("s4_energy", 32'(bus_a.energy),      8);
    check("s4_lstate", 32'(bus_a.left_state),  0);
    check("s4_rstate", 32'(bus_a.right_state), 0);

    // Short-timing instance: drain the pool with double grants (3 ticks per life cycle)
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus_b.btn_left  = 1'b1;
      bus_b.btn_right = 1'b1;
      step();
      bus_b.btn_left  = 1'b0;
      bus_b.btn_right = 1'b0;
      check("f_dbl_energy", 32'(bus_b.energy), 32'(6 - 2 * k));
      check("f_dbl_both",   32'({bus_b.left_shield_on, bus_b.right_shield_on}), 3);
      tick_n(3);
    end
    check("f_idle", 32'({bus_b.left_state, bus_b.right_state}), 0);

    // Empty pool: press denied
    bus_b.btn_left = 1'b1;
    step();
    check("f_e0_on",     32'(bus_b.left_shield_on), 0);
    check("f_e0_denied", 32'(bus_b.denied),         1);
    check("f_e0_energy", 32'(bus_b.energy),         0);
    step();
    check("f_e0_pulse",  32'(bus_b.denied),         0);
    bus_b.btn_left = 1'b0;

    // Recharge: 12 ticks already counted, 45th tick adds one unit
    tick_n(32);
    check("f_rc_44", 32'(bus_b.energy), 0);
    tick_n(1);
    check("f_rc_45", 32'(bus_b.energy), 1);

    // One unit, both press, rr_ptr at LEFT
    bus_b.btn_left  = 1'b1;
    bus_b.btn_right = 1'b1;
    step();
    bus_b.btn_left  = 1'b0;
    bus_b.btn_right = 1'b0;
    check("f_rr_l_left",   32'(bus_b.left_shield_on),  1);
    check("f_rr_l_right",  32'(bus_b.right_shield_on), 0);
    check("f_rr_l_energy", 32'(bus_b.energy),          0);
    check("f_rr_l_denied", 32'(bus_b.denied),          1);
    tick_n(45);
    check("f_rc_again", 32'(bus_b.energy), 1);

    // rr_ptr flipped to RIGHT
    bus_b.btn_left  = 1'b1;
    bus_b.btn_right = 1'b1;
    step();
    bus_b.btn_left  = 1'b0;
    bus_b.btn_right = 1'b0;
    check("f_rr_r_left",   32'(bus_b.left_shield_on),  0);
    check("f_rr_r_right",  32'(bus_b.right_shield_on), 1);
    check("f_rr_r_energy", 32'(bus_b.energy),          0);
    check("f_rr_r_denied", 32'(bus_b.denied),          1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
